// File: rtl/series_to_parrel.sv
// Serial-to-parallel frame receiver: frame_sync marks data bit 0, DATA_W data slots (LSB first)
// follow, then GUARD_LEN slots that must carry 0. All flags are registered one-cycle pulses.
module series_to_parrel #(
  parameter int DATA_W    = 8,
  parameter int GUARD_LEN = 8
) (
  input  logic              clk_16,
  input  logic              reset,
  input  logic              serial_in,
  input  logic              frame_sync,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              frame_abort,
  output logic [7:0]        frame_cnt
);

  localparam int FRAME_LEN = DATA_W + GUARD_LEN;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_GUARD = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, RECV, GUARD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   slot;
  logic [DATA_W-1:0]  shift;
  logic               guard_bad;
  logic [DATA_W-1:0]  shifted;
  logic [DATA_W-1:0]  first_word;

  // New bits enter at the MSB so that after DATA_W shifts bit 0 sits at the LSB.
  assign shifted    = {serial_in, shift[DATA_W-1:1]};
  assign first_word = DATA_W'(serial_in) << (DATA_W - 1);

  always_ff @(posedge clk_16 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      slot        <= '0;
      shift       <= '0;
      guard_bad   <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      frame_abort <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      frame_abort <= 1'b0;
      if (frame_sync) begin
        // Sync always restarts at slot 0; only an incomplete data phase counts as an abort.
        frame_abort <= (state == RECV);
        shift       <= first_word;
        slot        <= CNT_W'(1);
        guard_bad   <= 1'b0;
        state       <= RECV;
      end else begin
        case (state)
          IDLE: begin
            slot <= '0;
          end
          RECV: begin
            shift <= shifted;
            slot  <= slot + CNT_W'(1);
            if (slot == LAST_DATA) begin
              data_out   <= shifted;
              data_valid <= 1'b1;
              frame_cnt  <= frame_cnt + 8'd1;
              state      <= GUARD;
            end
          end
          GUARD: begin
            if (slot == LAST_GUARD) begin
              frame_err <= guard_bad | serial_in;
              guard_bad <= 1'b0;
              slot      <= '0;
              state     <= IDLE;
            end else begin
              guard_bad <= guard_bad | serial_in;
              slot      <= slot + CNT_W'(1);
            end
          end
          default: begin
            slot  <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_series_to_parrel.sv
// Self-checking bench for series_to_parrel: directed vectors, corner-case sequences and
// randomized traffic compared against a slot-position reference model.
module tb_series_to_parrel;

  localparam int DW = 8;
  localparam int GL = 8;
  localparam int FL = DW + GL;

  logic       clk_16 = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b0;
  logic       frame_sync = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       frame_abort;
  logic [7:0] frame_cnt;

  series_to_parrel #(.DATA_W(DW), .GUARD_LEN(GL)) dut (
    .clk_16      (clk_16),
    .reset       (reset),
    .serial_in   (serial_in),
    .frame_sync  (frame_sync),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .frame_abort (frame_abort),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk_16 = ~clk_16;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_cycles[$];

  // Reference model: position of the last sampled slot within the current frame.
  bit         m_active;
  int         m_pos;
  bit         m_bits[$];
  bit         m_gbad;
  logic [7:0] m_data;
  logic [7:0] m_cnt;
  bit         m_valid, m_err, m_abort;

  typedef struct {
    bit         s;
    bit         b;
    bit         valid;
    logic [7:0] data;
    logic [7:0] cnt;
  } vec_t;
  vec_t vecs[FL];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_pos = 0; m_bits = {}; m_gbad = 0;
    m_data = 8'd0; m_cnt = 8'd0; m_valid = 0; m_err = 0; m_abort = 0;
  endtask

  task automatic model_edge(input bit s, input bit b);
    int word;
    m_valid = 0; m_err = 0; m_abort = 0;
    if (s) begin
      m_abort  = m_active && (m_pos < DW - 1);
      m_active = 1; m_pos = 0; m_bits = {b}; m_gbad = 0;
    end else if (m_active) begin
      m_pos++;
      if (m_pos < DW) begin
        m_bits.push_back(b);
        if (m_pos == DW - 1) begin
          word = 0;
          foreach (m_bits[i]) word += int'(m_bits[i]) << i;
          m_data  = word[7:0];
          m_valid = 1;
          m_cnt   = m_cnt + 8'd1;
        end
      end else begin
        m_gbad |= b;
        if (m_pos == FL - 1) begin
          m_err = m_gbad;
          m_active = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("data_out", data_out, m_data);
    check("data_valid", data_valid, m_valid);
    check("frame_err", frame_err, m_err);
    check("frame_abort", frame_abort, m_abort);
    check("frame_cnt", frame_cnt, m_cnt);
  endtask

  task automatic step(input bit s, input bit b);
    @(negedge clk_16);
    frame_sync = s;
    serial_in  = b;
    @(posedge clk_16);
    cyc++;
    model_edge(s, b);
    #1;
    if (data_valid) valid_cycles.push_back(cyc);
    compare_all();
  endtask

  task automatic send_frame(input logic [7:0] w, input logic [7:0] gm);
    step(1'b1, w[0]);
    for (int i = 1; i < DW; i++) step(1'b0, w[i]);
    for (int g = 0; g < GL; g++) step(1'b0, gm[g]);
  endtask

  task automatic do_reset();
    @(negedge clk_16);
    reset = 1'b1;
    frame_sync = 1'b0;
    serial_in = 1'b0;
    #1;
    model_reset();
    check("rst_data_out", data_out, 8'd0);
    check("rst_flags", {data_valid, frame_err, frame_abort}, 3'b000);
    check("rst_frame_cnt", frame_cnt, 8'd0);
    @(negedge clk_16);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] w;
    a5 = 8'hA5;
    for (int i = 0; i < FL; i++) begin
      vecs[i].s     = (i == 0);
      vecs[i].b     = (i < DW) ? a5[i] : 1'b0;
      vecs[i].valid = (i == DW - 1);
      vecs[i].data  = (i >= DW - 1) ? 8'hA5 : 8'h00;
      vecs[i].cnt   = (i >= DW - 1) ? 8'd1 : 8'd0;
    end

    model_reset();
    do_reset();

    // Single 0xA5 frame from the vector table.
    for (int i = 0; i < FL; i++) begin
      step(vecs[i].s, vecs[i].b);
      check("vec_valid", data_valid, vecs[i].valid);
      check("vec_data", data_out, vecs[i].data);
      check("vec_cnt", frame_cnt, vecs[i].cnt);
      check("vec_err", frame_err, 1'b0);
    end

    // Guard violation: 1 in slot 12.
    do_reset();
    send_frame(8'h3C, 8'h10);
    check("guard_err_pulse", frame_err, 1'b1);
    check("guard_data", data_out, 8'h3C);
    check("guard_cnt", frame_cnt, 8'd1);
    step(1'b0, 1'b0);
    check("guard_err_one_cycle", frame_err, 1'b0);

    // Guard violation in the final slot only.
    do_reset();
    send_frame(8'h11, 8'h80);
    check("last_slot_err", frame_err, 1'b1);

    // Mid-frame resync at slot 4.
    do_reset();
    w = 8'h5A;
    for (int i = 0; i < 4; i++) step(i == 0, 1'b1);
    step(1'b1, w[0]);
    check("abort_pulse", frame_abort, 1'b1);
    check("abort_data_held", data_out, 8'h00);
    for (int i = 1; i < DW - 1; i++) step(1'b0, w[i]);
    check("abort_no_pulse", frame_abort, 1'b0);
    check("abort_data_still", data_out, 8'h00);
    step(1'b0, w[DW-1]);
    check("resync_data", data_out, 8'h5A);
    check("resync_valid", data_valid, 1'b1);
    for (int g = 0; g < GL; g++) step(1'b0, 1'b0);

    // Back-to-back frames.
    do_reset();
    valid_cycles = {};
    send_frame(8'h01, 8'h00);
    check("b2b_d0", data_out, 8'h01);
    send_frame(8'hFF, 8'h00);
    check("b2b_d1", data_out, 8'hFF);
    send_frame(8'h80, 8'h00);
    check("b2b_d2", data_out, 8'h80);
    check("b2b_count", valid_cycles.size(), 3);
    if (valid_cycles.size() == 3) begin
      check("b2b_gap1", valid_cycles[1] - valid_cycles[0], 16);
      check("b2b_gap2", valid_cycles[2] - valid_cycles[1], 16);
    end
    check("b2b_cnt", frame_cnt, 8'd3);

    // Reset at slot 5 of a frame.
    do_reset();
    send_frame(8'h42, 8'h00);
    for (int i = 0; i < 5; i++) step(i == 0, 1'b1);
    do_reset();
    send_frame(8'h77, 8'h00);
    check("post_reset_data", data_out, 8'h77);
    check("post_reset_cnt", frame_cnt, 8'd1);

    // Counter wrap.
    do_reset();
    for (int f = 0; f < 256; f++) send_frame(8'($urandom), 8'h00);
    check("wrap_zero", frame_cnt, 8'd0);
    send_frame(8'hC3, 8'h00);
    check("wrap_one", frame_cnt, 8'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 13) == 0), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
